// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display time-share arbiter.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_GAP  = 2'd3
  } seg_state_e;

  localparam int         DIGIT_W  = 16;
  localparam logic [3:0] BLANK_AN = 4'b1111;

endpackage

// File: rtl/seg_dwell_timer.sv
// Clearable up-counter that saturates at TERM and flags when it gets there.
module seg_dwell_timer #(
  parameter int W    = 4,
  parameter int TERM = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == W'(TERM));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (!done_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_share_arbiter.sv
// Two-requester display arbiter with minimum dwell before a forced handover.
// Define SEG_ARB_GAP_EN to blank the display for GAP cycles between owners.
module seg_share_arbiter
  import seg_pkg::*;
#(
  parameter int DWELL = 50000000,
  parameter int GAP   = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic [DIGIT_W-1:0] data0,
  input  logic               req1,
  input  logic [DIGIT_W-1:0] data1,
  output logic [1:0]         grant,
  output logic [DIGIT_W-1:0] digits,
  output logic               blank,
  output logic               handover
);

  localparam int CW = $clog2(DWELL);

  if (DWELL < 2 || GAP < 1) begin : g_bad_param
    $error("seg_share_arbiter: need DWELL >= 2 and GAP >= 1");
  end

  seg_state_e         state_q, state_d;
  logic               last_q, last_d;
  logic [CW-1:0]      cnt;
  logic               dwell_done;
  logic [1:0]         grant_q, grant_d, prev_q, prev_d;
  logic [DIGIT_W-1:0] digits_q, digits_d;
  logic               blank_q, blank_d, handover_q, handover_d;

`ifdef SEG_ARB_GAP_EN
  // The gap reuses the dwell counter, so it can never count past DWELL-1.
  if (GAP > DWELL) begin : g_bad_gap
    $error("seg_share_arbiter: GAP must not exceed DWELL");
  end
  logic gap_done;
  assign gap_done = (cnt == CW'(GAP - 1));
  localparam seg_state_e HAND_TO0 = ST_GAP;
  localparam seg_state_e HAND_TO1 = ST_GAP;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
  localparam seg_state_e HAND_TO0 = ST_OWN0;
  localparam seg_state_e HAND_TO1 = ST_OWN1;
`endif

  seg_dwell_timer #(.W(CW), .TERM(DWELL - 1)) u_timer (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (state_d != state_q),
    .cnt_o  (cnt),
    .done_o (dwell_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (req0)    state_d = ST_OWN0;
        else if (req1)    state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (req1 && (!req0 || dwell_done)) state_d = HAND_TO1;
        else if (!req0)                    state_d = ST_IDLE;
      end
      ST_OWN1: begin
        if (req0 && (!req1 || dwell_done)) state_d = HAND_TO0;
        else if (!req1)                    state_d = ST_IDLE;
      end
`ifdef SEG_ARB_GAP_EN
      // Pending target is the side that did not own before the gap.
      ST_GAP: begin
        if (gap_done) begin
          if (last_q ? req0 : req1)      state_d = last_q ? ST_OWN0 : ST_OWN1;
          else if (last_q ? req1 : req0) state_d = last_q ? ST_OWN1 : ST_OWN0;
          else                           state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == ST_OWN0)      last_d = 1'b0;
    else if (state_d == ST_OWN1) last_d = 1'b1;
  end

  // Output stage follows the registered state; prev tracks the last real owner
  // so that only direct (or through-gap) owner swaps raise handover.
  always_comb begin
    grant_d    = {state_q == ST_OWN1, state_q == ST_OWN0};
    blank_d    = (grant_d == 2'b00);
    digits_d   = digits_q;
    if (state_q == ST_OWN0)      digits_d = data0;
    else if (state_q == ST_OWN1) digits_d = data1;
    handover_d = (grant_d != 2'b00) && (prev_q != 2'b00) && (grant_d != prev_q);
    prev_d     = prev_q;
    if (grant_d != 2'b00)        prev_d = grant_d;
    else if (state_q == ST_IDLE) prev_d = 2'b00;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      grant_q    <= 2'b00;
      prev_q     <= 2'b00;
      digits_q   <= '0;
      blank_q    <= 1'b1;
      handover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      prev_q     <= prev_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
      handover_q <= handover_d;
    end
  end

  assign grant    = grant_q;
  assign digits   = digits_q;
  assign blank    = blank_q;
  assign handover = handover_q;

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Vector-table bench for seg_share_arbiter (DWELL=8, GAP=3) with an expected-output queue.
module tb_seg_share_arbiter;

  localparam int DWELL = 8;
  localparam int GAP   = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic [1:0]  grant;
  logic [15:0] digits;
  logic        blank, handover;

  seg_share_arbiter #(.DWELL(DWELL), .GAP(GAP)) dut (
    .clock    (clock),
    .reset    (reset),
    .req0     (req0),
    .data0    (data0),
    .req1     (req1),
    .data1    (data1),
    .grant    (grant),
    .digits   (digits),
    .blank    (blank),
    .handover (handover)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        r0, r1;
    logic [15:0] d0, d1;
    logic [1:0]  g;
    logic [15:0] dig;
    logic        bl, ho;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic addv(input logic r0, input logic r1, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [1:0] g, input logic [15:0] dig, input logic bl, input logic ho);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
    v.g = g; v.dig = dig; v.bl = bl; v.ho = ho;
    tbl.push_back(v);
  endtask

  task automatic expect_out(input logic [1:0] g, input logic [15:0] dig, input logic bl, input logic ho);
    vec_t v;
    v.r0 = 1'b0; v.r1 = 1'b0; v.d0 = '0; v.d1 = '0;
    v.g = g; v.dig = dig; v.bl = bl; v.ho = ho;
    exp_q.push_back(v);
  endtask

  task automatic check(input string name);
    vec_t e;
    e = exp_q.pop_front();
    total++;
    if (grant !== e.g || digits !== e.dig || blank !== e.bl || handover !== e.ho) begin
      bad++;
      $display("FAIL %s: got grant=%b digits=%h blank=%b handover=%b, want grant=%b digits=%h blank=%b handover=%b",
               name, grant, digits, blank, handover, e.g, e.dig, e.bl, e.ho);
    end
  endtask

  // Drive one vector before a rising edge, check outputs just after it.
  task automatic step(input vec_t v, input string name);
    req0 = v.r0; req1 = v.r1; data0 = v.d0; data1 = v.d1;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    check(name);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (2) @(posedge clock);
    #1;
    expect_out(2'b00, 16'h0000, 1'b1, 1'b0);
    check("reset_state");
    @(negedge clock);
    reset = 1'b0;

    // req0 alone, then req1 joins: forced handover after 8 owned cycles
    addv(1, 0, 16'h1234, 16'h0000, 2'b00, 16'h0000, 1, 0);
    addv(1, 0, 16'h1234, 16'h0000, 2'b01, 16'h1234, 0, 0);
    for (int k = 3; k <= 9; k++) addv(1, 1, 16'h1234, 16'hABCD, 2'b01, 16'h1234, 0, 0);
`ifdef SEG_ARB_GAP_EN
    for (int k = 10; k <= 12; k++) addv(1, 1, 16'h1234, 16'hABCD, 2'b00, 16'h1234, 1, 0);
    addv(1, 1, 16'h1234, 16'hABCD, 2'b10, 16'hABCD, 0, 1);
    addv(1, 1, 16'h1234, 16'h5678, 2'b10, 16'h5678, 0, 0);
`else
    addv(1, 1, 16'h1234, 16'hABCD, 2'b10, 16'hABCD, 0, 1);
    addv(1, 1, 16'h1234, 16'h5678, 2'b10, 16'h5678, 0, 0);
    // owner drops: immediate handover back, then idle holds digits
    addv(1, 0, 16'h1234, 16'h5678, 2'b10, 16'h5678, 0, 0);
    addv(1, 0, 16'h1111, 16'h5678, 2'b01, 16'h1111, 0, 1);
    addv(0, 0, 16'h1111, 16'h5678, 2'b01, 16'h1111, 0, 0);
    addv(0, 0, 16'h1111, 16'h5678, 2'b00, 16'h1111, 1, 0);
    // tie after requester 0 owned: requester 1 wins, no handover from idle
    addv(1, 1, 16'h1111, 16'h2222, 2'b00, 16'h1111, 1, 0);
    addv(1, 1, 16'h1111, 16'h2222, 2'b10, 16'h2222, 0, 0);
    addv(0, 0, 16'h1111, 16'h2222, 2'b10, 16'h2222, 0, 0);
    addv(0, 0, 16'h1111, 16'h2222, 2'b00, 16'h2222, 1, 0);
    // owner drops on the very cycle its dwell expires
    addv(1, 0, 16'h3333, 16'h2222, 2'b00, 16'h2222, 1, 0);
    for (int k = 21; k <= 27; k++) addv(1, 1, 16'h3333, 16'h4444, 2'b01, 16'h3333, 0, 0);
    addv(0, 1, 16'h3333, 16'h4444, 2'b01, 16'h3333, 0, 0);
    addv(0, 1, 16'h3333, 16'h4444, 2'b10, 16'h4444, 0, 1);
    addv(0, 1, 16'h3333, 16'h4444, 2'b10, 16'h4444, 0, 0);
`endif

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i + 1));

    // asynchronous reset while requester 1 owns the display
    #1 reset = 1'b1;
    #1;
    expect_out(2'b00, 16'h0000, 1'b1, 1'b0);
    check("async_reset");
    @(negedge clock);
    reset = 1'b0;
    v.r0 = 1; v.r1 = 1; v.d0 = 16'h9999; v.d1 = 16'h7777;
    v.g = 2'b00; v.dig = 16'h0000; v.bl = 1; v.ho = 0;
    step(v, "post_reset_idle");
    v.g = 2'b01; v.dig = 16'h9999; v.bl = 0; v.ho = 0;
    step(v, "post_reset_tie_req0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_share_arbiter.md
# seg_share_arbiter

Two-requester time-share arbiter for the Basys-2 four-digit seven-segment display. Two producers can each own the display; examples are the X/Y position hex readout and a scrolling-text source. The arbiter grants the display to one producer at a time and enforces a minimum dwell time before handing it over. It then registers the owner's 16-bit nibble word toward the multiplexing decoder. The arbiter sits between the producers and the existing digit-mux/segment-decode logic, and it drives a blank flag that the decoder uses to force all anodes high.

## Interface
- DWELL, 50000000, minimum cycles an owner keeps the display while the other side is requesting (1 s at 50 MHz); legal range ≥ 2.
- GAP, 1000, blank cycles inserted between owners; used only when SEG_ARB_GAP_EN is defined; legal range ≥ 1.

- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req0  in  1  requester 0 wants the display; level-sensitive.
- data0  in  16  requester 0 digits, {fourth, third, second, first} nibbles.
- req1  in  1  requester 1 wants the display.
- data1  in  16  requester 1 digits.
- grant  out  2  one-hot current owner; 2'b00 when idle or in gap.
- digits  out  16  registered nibble word to the digit mux.
- blank  out  1  1 = decoder must drive an = 4'b1111.
- handover  out  1  one-cycle pulse on the cycle the grant changes owner (0→1 or 1→0 only).

## Operation
- States: IDLE, OWN0, OWN1, plus GAP when SEG_ARB_GAP_EN is defined.
- IDLE:
  - Neither request → stay in IDLE.
  - Only one request → grant that requester.
  - Both requests → grant the requester that is not `last`; `last` resets to 1, so requester 0 wins the first tie.
- OWNx, own request dropped:
  - Other side requesting → hand over to it.
  - Otherwise → IDLE.
- OWNx, own request still held:
  - Other side requesting and dwell count = DWELL-1 → hand over.
  - Otherwise stay.
- Dwell counter:
  - Clears to 0 on entry to any OWNx.
  - Increments each cycle and saturates at DWELL-1.
  - Width is the ceiling of log2(DWELL) bits.
- `last` updates to x on entry to OWNx.
- On every cycle in OWNx, digits <= data_x, so the owner's live data tracks with one cycle of latency.
- In IDLE and GAP, digits holds its last value and blank = 1.
- A request held continuously with no competitor keeps its grant indefinitely.
- Handover from a dropped request is immediate and is not subject to dwell.

## Timing
- Reset values: grant = 2'b00, digits = 16'h0000, blank = 1, handover = 0, state = IDLE, `last` = 1, counter = 0.
- All outputs are registered; there is no combinational path from req or data to any output.
- Request latency: req sampled high in IDLE at edge N → grant and blank = 0 valid after edge N+1, and digits = data sampled at edge N+1.
- Forced handover: occurs on the edge where the counter equals DWELL-1 and the other request is high. The new grant is visible the next cycle, and handover pulses in that same cycle.
- Simultaneous events: if the owner drops req on the same cycle the dwell expires, the grant goes to the other side when it is requesting, otherwise to IDLE. The result is one transition, not two.
- Reset asserted mid-ownership: outputs go to reset values asynchronously. After release, arbitration restarts from IDLE with `last` = 1.

## Configuration
- SEG_ARB_GAP_EN defined:
  - Every owner-to-owner handover passes through GAP for exactly GAP cycles, with grant = 0 and blank = 1. The GAP counter reuses the dwell counter.
  - Exiting GAP grants the pending target, provided its req is still high; otherwise the other side if it is requesting, otherwise IDLE.
  - handover pulses on the cycle the new grant appears.
- SEG_ARB_GAP_EN undefined: no GAP state; handover is back-to-back.

## Structure
- Shared package seg_pkg holds:
  - the state encoding constants (IDLE, OWN0, OWN1, GAP);
  - the 16-bit digit-word width;
  - the blank-anode constant 4'b1111.
- One sub-module: seg_dwell_timer, a clearable saturating counter with parameterised terminal count and a done flag. The arbiter instantiates it once.

## Test plan
Simulate with DWELL = 8 and GAP = 3.
- Reset, then req0 = 1 with data0 = 16'h1234 → grant = 01 and digits = 16'h1234 two edges after req; blank = 0; handover stays 0.
- req0 held and req1 raised at cycle 2 of ownership → grant stays 01 until the counter reaches 7, then grant = 10 with a one-cycle handover pulse and digits = data1 next cycle.
- Both requests raised together out of reset → grant = 01. Drop req0 → grant = 10 on the next edge. Drop req1 → IDLE, blank = 1, digits holds 16'h (last data1).
- req0 drops on the same cycle the dwell expires, with req1 high → single transition to grant = 10; no intermediate IDLE cycle is visible.
- Assert reset during OWN1 → grant = 00, blank = 1, digits = 0 without a clock edge. After release with both requests high → grant = 01.
- With SEG_ARB_GAP_EN, forced handover 0→1 → grant = 00 and blank = 1 for exactly 3 cycles, then grant = 10 with the handover pulse.
